circuit5_operand_seq: RTL and testbench

CIRCUIT5_OPERAND_SEQ -- requirements
Module: circuit5_operand_seq

---
 rtl/circuit5_operand_seq_if.sv | 26 ++
 rtl/circuit5_operand_seq.sv | 105 ++++++++++
 tb/tb_circuit5_operand_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/circuit5_operand_seq_if.sv
// Operand/result handshake bundle between the operand sequencer and its neighbours.
// master = upstream producer + downstream datapath + consumer side; slave = sequencer.
interface circuit5_operand_seq_if #(
  parameter int DATAWIDTH = 64
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] in_a, in_b, in_c, in_d, in_zero;
  logic [DATAWIDTH-1:0] a, b, c, d, zero;
  logic [DATAWIDTH-1:0] z_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_z;
  logic                 busy;
  logic                 err_divzero;

  modport master (
    output in_valid, in_a, in_b, in_c, in_d, in_zero, z_in, out_ready,
    input  in_ready, a, b, c, d, zero, out_valid, out_z, busy, err_divzero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_d, in_zero, z_in, out_ready,
    output in_ready, a, b, c, d, zero, out_valid, out_z, busy, err_divzero
  );
endinterface

// File: rtl/circuit5_operand_seq.sv
// Operand sequencer: holds a tuple on a..zero for SETTLE_CYCLES, then captures z_in.
// Optional DIVZERO_CHECK_EN short-circuits zero divisors to an error result.
module circuit5_operand_seq #(
  parameter int DATAWIDTH     = 64,
  parameter int SETTLE_CYCLES = 3
) (
  input logic                   Clk,
  input logic                   Rst,
  circuit5_operand_seq_if.slave bus
);
  localparam int SC_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CW     = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SC_EFF);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [DATAWIDTH-1:0] a_q, b_q, c_q, d_q, zero_q, z_q;
  logic                 vld_q, busy_q, err_q, dz_q;
  logic                 dz_d;

`ifdef DIVZERO_CHECK_EN
  assign dz_d = (bus.in_b == '0) || (bus.in_d == '0);
`else
  assign dz_d = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      zero_q  <= '0;
      z_q     <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_q     <= bus.in_a;
          b_q     <= bus.in_b;
          c_q     <= bus.in_c;
          d_q     <= bus.in_d;
          zero_q  <= bus.in_zero;
          cnt_q   <= CNT_LOAD;
          dz_q    <= dz_d;
          busy_q  <= 1'b1;
          state_q <= SETTLE;
        end
        SETTLE: begin
          // Zero-divisor tuples skip the wait; the datapath result would be garbage.
          if (dz_q) begin
            z_q     <= '0;
            err_q   <= 1'b1;
            cnt_q   <= '0;
            vld_q   <= 1'b1;
            state_q <= DONE;
          end else if (cnt_q <= CW'(1)) begin
            z_q     <= bus.z_in;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            vld_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: if (bus.out_ready) begin
          vld_q   <= 1'b0;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
          dz_q    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          vld_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // in_ready is gated by Rst so it reads 0 while reset is held, yet 1 on release.
  assign bus.in_ready    = Rst & ~busy_q;
  assign bus.a           = a_q;
  assign bus.b           = b_q;
  assign bus.c           = c_q;
  assign bus.d           = d_q;
  assign bus.zero        = zero_q;
  assign bus.out_valid   = vld_q;
  assign bus.out_z       = z_q;
  assign bus.busy        = busy_q;
`ifdef DIVZERO_CHECK_EN
  assign bus.err_divzero = err_q;
`else
  assign bus.err_divzero = 1'b0;
`endif
endmodule

// File: tb/tb_circuit5_operand_seq.sv
// Directed bench for circuit5_operand_seq with a registered divide/mod/select datapath model.
module tb_circuit5_operand_seq;
  localparam int DW = 64;
  localparam int SC = 3;
`ifdef DIVZERO_CHECK_EN
  localparam int          DZ_LAT = 1;
  localparam logic [63:0] DZ_Z   = 64'd0;
  localparam logic        DZ_E   = 1'b1;
`else
  localparam int          DZ_LAT = 3;
  localparam logic [63:0] DZ_Z   = 64'd4;
  localparam logic        DZ_E   = 1'b0;
`endif

  typedef struct { logic [63:0] z; logic e; } exp_t;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   acc_cyc = 0;
  exp_t sb[$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  circuit5_operand_seq_if #(.DATAWIDTH(DW)) bus();

  circuit5_operand_seq #(.DATAWIDTH(DW), .SETTLE_CYCLES(SC)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  // Downstream datapath: (a % b == zero) ? a / b : c / d, registered.
  function automatic logic [63:0] dp(input logic [63:0] a, b, c, d, z);
    logic [63:0] m, qa, qc;
    m  = (b == 0) ? a : a % b;
    qa = (b == 0) ? 64'd0 : a / b;
    qc = (d == 0) ? 64'd0 : c / d;
    return (m == z) ? qa : qc;
  endfunction

  always @(posedge Clk) bus.z_in <= dp(bus.a, bus.b, bus.c, bus.d, bus.zero);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input string tag, input logic [63:0] ta, tb_, tc, td, tz,
                      input logic [63:0] ez, input logic ee, input bit push);
    bit ok;
    ok = 1'b0;
    bus.in_a = ta; bus.in_b = tb_; bus.in_c = tc; bus.in_d = td; bus.in_zero = tz;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1 ok = bus.in_ready;
      @(negedge Clk);
    end
    bus.in_valid = 1'b0;
    acc_cyc = cyc;
    if (!ok) chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
    else if (push) sb.push_back('{z: ez, e: ee});
  endtask

  task automatic wait_result(input string tag, input int lat);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.out_valid) seen = 1'b1;
      else @(negedge Clk);
    end
    if (!seen) begin
      chk({tag, "_result_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(lat));
      if (sb.size() == 0) chk({tag, "_sb_underflow"}, 64'd0, 64'd1);
      else begin
        e = sb.pop_front();
        chk({tag, "_z"}, bus.out_z, e.z);
        chk({tag, "_err"}, 64'(bus.err_divzero), 64'(e.e));
      end
      chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
      chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
  endtask

  initial begin
    int rel, a0, a1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_d = '0; bus.in_zero = '0;

    // Reset state
    repeat (3) @(negedge Clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_err", 64'(bus.err_divzero), 64'd0);
    chk("rst_a", bus.a, 64'd0);
    chk("rst_out_z", bus.out_z, 64'd0);

    // First accept on the first edge after release; a%b==0 selects a/b
    Rst = 1'b1; rel = cyc; bus.out_ready = 1'b1;
    send("t1", 100, 10, 7, 2, 0, 10, 1'b0, 1'b1);
    chk("t1_first_edge_accept", 64'(acc_cyc - rel), 64'd1);
    wait_result("t1", SC);
    @(negedge Clk);
    chk("t1_idle_in_ready", 64'(bus.in_ready), 64'd1);
    chk("t1_idle_valid", 64'(bus.out_valid), 64'd0);
    chk("t1_a_held", bus.a, 64'd100);

    // 7%2 != 0 selects c/d; consumer stalls 5 cycles while in_valid pulses
    bus.out_ready = 1'b0;
    send("t2", 7, 2, 9, 3, 0, 3, 1'b0, 1'b1);
    wait_result("t2", SC);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0); bus.in_a = 64'd55; bus.in_b = 64'd5;
      @(negedge Clk);
      chk("t2_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("t2_hold_z", bus.out_z, 64'd3);
      chk("t2_hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("t2_hold_a", bus.a, 64'd7);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge Clk);
    chk("t2_release_valid", 64'(bus.out_valid), 64'd0);
    chk("t2_release_busy", 64'(bus.busy), 64'd0);
    chk("t2_release_in_ready", 64'(bus.in_ready), 64'd1);
    chk("t2_no_stray_accept", bus.a, 64'd7);

    // Zero divisor
    send("dz", 5, 0, 8, 2, 0, DZ_Z, DZ_E, 1'b1);
    wait_result("dz", DZ_LAT);
    @(negedge Clk);

    // Reset during the second SETTLE cycle aborts with no result
    send("ab", 90, 9, 4, 2, 0, 0, 1'b0, 1'b0);
    @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    chk("ab_valid", 64'(bus.out_valid), 64'd0);
    chk("ab_busy", 64'(bus.busy), 64'd0);
    chk("ab_in_ready", 64'(bus.in_ready), 64'd0);
    chk("ab_a", bus.a, 64'd0);
    chk("ab_out_z", bus.out_z, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("ab_no_valid", 64'(bus.out_valid), 64'd0);
    end
    Rst = 1'b1;
    send("t3", 81, 9, 1, 1, 0, 9, 1'b0, 1'b1);
    wait_result("t3", SC);
    @(negedge Clk);

    // Back-to-back with out_ready held: one accept per SC+2 edges, in order
    send("b0", 50, 7, 30, 6, 0, 5, 1'b0, 1'b1);
    a0 = acc_cyc;
    wait_result("b0", SC);
    send("b1", 64, 8, 3, 1, 0, 8, 1'b0, 1'b1);
    a1 = acc_cyc;
    chk("b1_spacing", 64'(a1 - a0), 64'(SC + 2));
    wait_result("b1", SC);
    send("b2", 9, 4, 21, 7, 1, 2, 1'b0, 1'b1);
    chk("b2_spacing", 64'(acc_cyc - a1), 64'(SC + 2));
    wait_result("b2", SC);
    @(negedge Clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
